// File: rtl/rv64g_l2_mshr_ctrl_if.sv
// Channel bundle for the L2 MSHR controller: acquire request, probe issue,
// probe ack, grant and finish. The controller connects through the slave modport.
interface rv64g_l2_mshr_ctrl_if #(
    parameter int ADDR_W   = 64,
    parameter int SOURCE_W = 6,
    parameter int TYPE_W   = 3,
    parameter int CORES    = 4,
    parameter int NUM_MSHR = 4
);
    localparam int MW = $clog2(NUM_MSHR);
    localparam int CW = $clog2(CORES);

    logic                req_valid_i;
    logic                req_ready_o;
    logic [ADDR_W-1:0]   req_addr_i;
    logic [SOURCE_W-1:0] req_source_i;
    logic [TYPE_W-1:0]   req_type_i;
    logic [CORES-1:0]    req_sharers_i;

    logic                probe_valid_o;
    logic                probe_ready_i;
    logic [CW-1:0]       probe_core_o;
    logic [ADDR_W-1:0]   probe_addr_o;
    logic [MW-1:0]       probe_mshr_o;

    logic                pack_valid_i;
    logic [MW-1:0]       pack_mshr_i;
    logic [CW-1:0]       pack_core_i;

    logic                grant_valid_o;
    logic                grant_ready_i;
    logic [MW-1:0]       grant_mshr_o;
    logic [ADDR_W-1:0]   grant_addr_o;
    logic [SOURCE_W-1:0] grant_source_o;
    logic [TYPE_W-1:0]   grant_type_o;

    logic                finish_valid_i;
    logic [MW-1:0]       finish_mshr_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_source_i, req_type_i, req_sharers_i,
        output req_ready_o,
        output probe_valid_o, probe_core_o, probe_addr_o, probe_mshr_o,
        input  probe_ready_i,
        input  pack_valid_i, pack_mshr_i, pack_core_i,
        output grant_valid_o, grant_mshr_o, grant_addr_o, grant_source_o, grant_type_o,
        input  grant_ready_i,
        input  finish_valid_i, finish_mshr_i
    );

    modport master (
        output req_valid_i, req_addr_i, req_source_i, req_type_i, req_sharers_i,
        input  req_ready_o,
        input  probe_valid_o, probe_core_o, probe_addr_o, probe_mshr_o,
        output probe_ready_i,
        output pack_valid_i, pack_mshr_i, pack_core_i,
        input  grant_valid_o, grant_mshr_o, grant_addr_o, grant_source_o, grant_type_o,
        output grant_ready_i,
        output finish_valid_i, finish_mshr_i
    );
endinterface

// File: rtl/rv64g_l2_mshr_ctrl.sv
// L2 miss-status entry controller: allocate, probe sharers, collect acks, grant, free.
// Optional stall counters are enabled by defining RV64G_L2_MSHR_CTRL_PERF_EN.
module rv64g_l2_mshr_ctrl #(
    parameter int ADDR_W   = 64,
    parameter int SOURCE_W = 6,
    parameter int TYPE_W   = 3,
    parameter int CORES    = 4,
    parameter int NUM_MSHR = 4,
    parameter int LINE_OFF = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    rv64g_l2_mshr_ctrl_if.slave bus,
    output logic [NUM_MSHR-1:0] busy_mask_o
`ifdef RV64G_L2_MSHR_CTRL_PERF_EN
    ,
    output logic [31:0]         stall_full_cnt_o,
    output logic [31:0]         stall_conf_cnt_o
`endif
);
    localparam int MW = $clog2(NUM_MSHR);
    localparam int CW = $clog2(CORES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE,
        ST_WAIT_ACK,
        ST_GRANT,
        ST_WAIT_FIN
    } mshr_state_e;

    typedef struct packed {
        mshr_state_e         state;
        logic [ADDR_W-1:0]   addr;
        logic [SOURCE_W-1:0] source;
        logic [TYPE_W-1:0]   rtype;
        logic [CORES-1:0]    to_issue;
        logic [CORES-1:0]    ack_wait;
    } entry_t;

    entry_t ent_q [NUM_MSHR];
    entry_t ent_d [NUM_MSHR];
    logic [MW-1:0] rr_ptr_q, rr_ptr_d;

    logic                probe_valid_q;
    logic [CW-1:0]       probe_core_q;
    logic [MW-1:0]       probe_mshr_q;
    logic [ADDR_W-1:0]   probe_addr_q;
    logic                grant_valid_q;
    logic [MW-1:0]       grant_mshr_q;
    logic [ADDR_W-1:0]   grant_addr_q;
    logic [SOURCE_W-1:0] grant_source_q;
    logic [TYPE_W-1:0]   grant_type_q;

    logic          any_idle;
    logic          conflict;
    logic          alloc;
    logic [MW-1:0] alloc_idx;
    logic          probe_fire;
    logic          grant_fire;

    // Free-entry search and line-address conflict check against all occupied entries.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        any_idle  = 1'b0;
        conflict  = 1'b0;
        alloc_idx = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (ent_q[i].state == ST_IDLE) begin
                any_idle  = 1'b1;
                alloc_idx = MW'(i);
            end else if (ent_q[i].addr[ADDR_W-1:LINE_OFF] ==
                         bus.req_addr_i[ADDR_W-1:LINE_OFF]) begin
                conflict = 1'b1;
            end
        end
    end

    assign bus.req_ready_o = any_idle && !conflict;
    assign alloc           = bus.req_valid_i && bus.req_ready_o;
    assign probe_fire      = probe_valid_q && bus.probe_ready_i;
    assign grant_fire      = grant_valid_q && bus.grant_ready_i;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (probe_fire) begin
            rr_ptr_d = probe_mshr_q + MW'(1);
        end
        for (int i = 0; i < NUM_MSHR; i++) begin
            ent_d[i] = ent_q[i];
            case (ent_q[i].state)
                ST_IDLE: begin
                    if (alloc && alloc_idx == MW'(i)) begin
                        ent_d[i].addr     = bus.req_addr_i;
                        ent_d[i].source   = bus.req_source_i;
                        ent_d[i].rtype    = bus.req_type_i;
                        ent_d[i].to_issue = bus.req_sharers_i;
                        ent_d[i].ack_wait = bus.req_sharers_i;
                        ent_d[i].state    = (bus.req_sharers_i == '0) ? ST_GRANT : ST_PROBE;
                    end
                end
                ST_PROBE, ST_WAIT_ACK: begin
                    // Acks only count for cores whose probe has already gone out.
                    if (bus.pack_valid_i && bus.pack_mshr_i == MW'(i) &&
                        !ent_q[i].to_issue[bus.pack_core_i]) begin
                        ent_d[i].ack_wait[bus.pack_core_i] = 1'b0;
                    end
                    if (ent_q[i].state == ST_PROBE) begin
                        if (probe_fire && probe_mshr_q == MW'(i)) begin
                            ent_d[i].to_issue[probe_core_q] = 1'b0;
                        end
                        if (ent_d[i].to_issue == '0) begin
                            ent_d[i].state = ST_WAIT_ACK;
                        end
                    end else if (ent_q[i].ack_wait == '0) begin
                        ent_d[i].state = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (grant_fire && grant_mshr_q == MW'(i)) begin
                        ent_d[i].state = ST_WAIT_FIN;
                    end
                end
                ST_WAIT_FIN: begin
                    if (bus.finish_valid_i && bus.finish_mshr_i == MW'(i)) begin
                        ent_d[i].state = ST_IDLE;
                    end
                end
                default: ent_d[i].state = ST_IDLE;
            endcase
        end
    end

    // Channel selection is evaluated on next state so the outputs can be registered
    // and still track the entry file with no extra cycle of latency.
    logic          probe_hit;
    logic [MW-1:0] probe_sel;
    logic [MW-1:0] scan;
    logic [CW-1:0] probe_core_sel;
    logic          grant_hit;
    logic [MW-1:0] grant_sel;

    always_comb begin
        probe_hit      = 1'b0;
        probe_sel      = '0;
        scan           = '0;
        probe_core_sel = '0;
        grant_hit      = 1'b0;
        grant_sel      = '0;
        for (int k = 0; k < NUM_MSHR; k++) begin
            scan = rr_ptr_d + MW'(k);
            if (!probe_hit && ent_d[scan].state == ST_PROBE && ent_d[scan].to_issue != '0) begin
                probe_hit = 1'b1;
                probe_sel = scan;
            end
        end
        for (int c = CORES - 1; c >= 0; c--) begin
            if (ent_d[probe_sel].to_issue[c]) begin
                probe_core_sel = CW'(c);
            end
        end
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (ent_d[i].state == ST_GRANT) begin
                grant_hit = 1'b1;
                grant_sel = MW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the entry file is small control state, so it is reset along with
            // everything else; that keeps the data outputs at zero out of reset.
            for (int i = 0; i < NUM_MSHR; i++) begin
                ent_q[i] <= '0;
            end
            rr_ptr_q       <= '0;
            probe_valid_q  <= 1'b0;
            probe_core_q   <= '0;
            probe_mshr_q   <= '0;
            probe_addr_q   <= '0;
            grant_valid_q  <= 1'b0;
            grant_mshr_q   <= '0;
            grant_addr_q   <= '0;
            grant_source_q <= '0;
            grant_type_q   <= '0;
        end else begin
            ent_q          <= ent_d;
            rr_ptr_q       <= rr_ptr_d;
            probe_valid_q  <= probe_hit;
            probe_core_q   <= probe_hit ? probe_core_sel : '0;
            probe_mshr_q   <= probe_hit ? probe_sel : '0;
            probe_addr_q   <= probe_hit ? ent_d[probe_sel].addr : '0;
            grant_valid_q  <= grant_hit;
            grant_mshr_q   <= grant_hit ? grant_sel : '0;
            grant_addr_q   <= grant_hit ? ent_d[grant_sel].addr : '0;
            grant_source_q <= grant_hit ? ent_d[grant_sel].source : '0;
            grant_type_q   <= grant_hit ? ent_d[grant_sel].rtype : '0;
        end
    end

    assign bus.probe_valid_o  = probe_valid_q;
    assign bus.probe_core_o   = probe_core_q;
    assign bus.probe_mshr_o   = probe_mshr_q;
    assign bus.probe_addr_o   = probe_addr_q;
    assign bus.grant_valid_o  = grant_valid_q;
    assign bus.grant_mshr_o   = grant_mshr_q;
    assign bus.grant_addr_o   = grant_addr_q;
    assign bus.grant_source_o = grant_source_q;
    assign bus.grant_type_o   = grant_type_q;

    always_comb begin
        busy_mask_o = '0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            busy_mask_o[i] = (ent_q[i].state != ST_IDLE);
        end
    end

`ifdef RV64G_L2_MSHR_CTRL_PERF_EN
    logic [31:0] stall_full_q;
    logic [31:0] stall_conf_q;

    // Saturating stall counters: full file vs. blocked by a same-line entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_full_q <= '0;
            stall_conf_q <= '0;
        end else begin
            if (bus.req_valid_i && !any_idle && stall_full_q != 32'hFFFF_FFFF) begin
                stall_full_q <= stall_full_q + 32'd1;
            end
            if (bus.req_valid_i && any_idle && conflict && stall_conf_q != 32'hFFFF_FFFF) begin
                stall_conf_q <= stall_conf_q + 32'd1;
            end
        end
    end

    assign stall_full_cnt_o = stall_full_q;
    assign stall_conf_cnt_o = stall_conf_q;
`endif

endmodule

// File: doc/rv64g_l2_mshr_ctrl.md
Name: rv64g_l2_mshr_ctrl

Overview:
Controller for a file of NUM_MSHR L2 miss-status entries. It accepts acquire requests from the L2 request pipe and rejects any request that is full or address-conflicting. It allocates the lowest free entry, sequences probes to the sharer cores, and collects probe acks. It then arbitrates the grant channel back to the requester and frees the entry on the requester's finish.

Parameters:
ADDR_W, 64, physical address width
SOURCE_W, 6, requester source ID width
TYPE_W, 3, request opcode width
CORES, 4, number of coherent cores (probe targets)
NUM_MSHR, 4, number of entries (power of 2, >=2)
LINE_OFF, 6, log2 line size; conflicts compare addr[ADDR_W-1:LINE_OFF]

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  acquire request valid
req_ready_o  out  1  request accepted when valid&&ready
req_addr_i  in  ADDR_W  request address
req_source_i  in  SOURCE_W  requester source
req_type_i  in  TYPE_W  request opcode
req_sharers_i  in  CORES  cores to probe (from directory)
probe_valid_o  out  1  probe issue valid
probe_ready_i  in  1  probe channel ready
probe_core_o  out  $clog2(CORES)  target core
probe_addr_o  out  ADDR_W  probed address (entry address)
probe_mshr_o  out  $clog2(NUM_MSHR)  issuing entry
pack_valid_i  in  1  probe ack valid (always accepted)
pack_mshr_i  in  $clog2(NUM_MSHR)  acked entry
pack_core_i  in  $clog2(CORES)  acking core
grant_valid_o  out  1  grant valid
grant_ready_i  in  1  grant channel ready
grant_mshr_o  out  $clog2(NUM_MSHR)  granting entry
grant_addr_o  out  ADDR_W  grant address
grant_source_o  out  SOURCE_W  grant destination source
grant_type_o  out  TYPE_W  original request opcode
finish_valid_i  in  1  requester finish (always accepted)
finish_mshr_i  in  $clog2(NUM_MSHR)  entry to free
busy_mask_o  out  NUM_MSHR  per-entry occupied flag

Behaviour:
- Reset: all entries IDLE with masks cleared. req_ready_o=1, probe_valid_o=0, grant_valid_o=0, busy_mask_o=0, and all data outputs are 0. Reset asserted mid-operation drops all in-flight entries immediately.
- Per-entry state: IDLE -> PROBE -> WAIT_ACK -> GRANT -> WAIT_FIN -> IDLE. Each entry holds addr, source, type, to_issue[CORES], ack_wait[CORES].
- req_ready_o is combinational. It is 1 only when at least one entry is IDLE and no non-IDLE entry matches the line address of req_addr_i. This path from req_addr_i to req_ready_o is intentional.
- Accept at edge T: the lowest-index IDLE entry loads addr, source and type, and sets to_issue=ack_wait=req_sharers_i.
  - At T+1 the entry is in PROBE.
  - If req_sharers_i==0, the entry is in GRANT at T+1 instead.
- Probe issue:
  - probe_valid_o=1 when any entry is in PROBE with to_issue!=0.
  - Entry choice is round-robin: the pointer advances past the winner on each probe handshake.
  - Core choice within the entry is the lowest set bit of to_issue.
  - The outputs are driven from registered state only.
  - On probe_valid_o&&probe_ready_i, the chosen bit of to_issue is cleared.
  - When to_issue becomes 0, the entry moves to WAIT_ACK.
- Probe acks:
  - pack_valid_i clears ack_wait[pack_core_i] of the named entry only if that entry is in PROBE/WAIT_ACK and the core's to_issue bit is already 0.
  - Any other ack is ignored: idle entry, duplicate, or a core not yet probed.
  - An ack and a probe handshake to the same entry in the same cycle both take effect.
  - WAIT_ACK with ack_wait==0 moves to GRANT on the next edge.
- Grant: fixed priority, lowest-index GRANT entry. On grant_valid_o&&grant_ready_i, that entry moves to WAIT_FIN.
- Finish: finish_valid_i on a WAIT_FIN entry moves it to IDLE at the next edge. The freed entry is visible to req_ready_o the following cycle; there is no same-cycle bypass. A finish to a non-WAIT_FIN entry is ignored.
- Simultaneous allocate and finish in the same cycle are independent; the allocation never selects the entry being freed that cycle.
- busy_mask_o[i]=1 when entry i is not IDLE.

Optional Feature:
RV64G_L2_MSHR_CTRL_PERF_EN:
- When defined, adds output stall_full_cnt_o[31:0] and output stall_conf_cnt_o[31:0].
  - stall_full_cnt_o increments on each cycle with req_valid_i=1 and all entries busy.
  - stall_conf_cnt_o increments on each cycle with req_valid_i=1, a free entry available, and an address conflict.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. After reset, req addr=0x1000, src=0x1A, type=4, sharers=4'b1101 -> entry 0 allocated, busy_mask_o=0001. Probes issue to cores 0, 2, 3 in that order on consecutive cycles with probe_ready_i=1; probe_addr_o=0x1000.
2. Ack cores 2, 0, 3 -> after the last ack, grant_valid_o=1 with mshr=0, source=0x1A, type=4. Hold grant_ready_i=0 for 3 cycles: the grant stays stable. Then handshake, send finish mshr=0 -> busy_mask_o=0000.
3. Entry 0 busy at 0x1000; request 0x1020 (same line) -> req_ready_o=0. Request 0x2000 -> accepted into entry 1.
4. Fill all 4 entries with sharers=0 -> each enters GRANT, grants emerge in order 0, 1, 2, 3, and req_ready_o=0 while full. Finish entry 2 -> the next request is allocated to entry 2.
5. Entries 0 and 1 both in PROBE with sharers=4'b0011 -> issue order is e0/c0, e1/c0, e0/c1, e1/c1. An ack for core 1 before it is probed is ignored, and ack_wait is unchanged.
6. Assert rst_n=0 mid-probe -> all outputs return to reset values asynchronously, and the entry is reallocated cleanly after release.
